cdc_fifo_rd_ctrl: RTL
=====================

Name: cdc_fifo_rd_ctrl

Overview:
- Read-side controller for the dual-clock FIFO inside tt_um_pa1mantri_cdc_fifo; it is the reader counterpart to the existing write-side logic.
- Runs entirely in the read clock domain:
  - consumes the already-synchronized Gray write pointer;
  - derives empty and occupancy level;
  - drives the FIFO memory read port;
  - presents data on a valid/ready stream through a 2-entry output buffer.
- Publishes its Gray read pointer, registered, for synchronization back into the write domain.

Parameters:
- DATA_W, 8, data word width
- ADDR_W, 3, memory address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits

Ports:
- clk  in  1  read-domain clock
- rst  in  1  asynchronous, active-high reset
- wptr_gray_sync  in  ADDR_W+1  write pointer in Gray code, already 2-flop synchronized into clk domain
- rptr_gray  out  ADDR_W+1  registered Gray read pointer, sent to the write-domain synchronizer
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  memory read address
- rd_data  in  DATA_W  memory read data, valid the cycle after rd_en (registered read)
- m_data  out  DATA_W  output stream data
- m_valid  out  1  output stream valid
- m_ready  in  1  output stream ready
- empty  out  1  no unread entries remain in memory
- level  out  ADDR_W+1  entries still in memory (excludes in-flight and buffered entries)

Behaviour:
- Decided: one clock, clk; reset rst is asynchronous and active-high.
- Reset (async assert, sync release):
  - rptr_bin, rptr_gray, m_data and level = 0;
  - m_valid = 0, rd_en = 0, empty = 1;
  - in-flight read and buffered entries are discarded.
- Pointers:
  - rptr_bin increments by 1 per rd_en and wraps modulo 2**(ADDR_W+1);
  - rptr_gray is registered as bin2gray(rptr_bin_next), so it changes in the same edge as rptr_bin;
  - rptr_gray changes by exactly one bit per increment.
- empty = (rptr_gray == wptr_gray_sync). This is combinational from registered state and the synchronized input.
- level = gray2bin(wptr_gray_sync) - rptr_bin, computed modulo 2**(ADDR_W+1).
- rd_addr = rptr_bin[ADDR_W-1:0].
- Credit rule:
  - occ = buffered entries (0..2) + in-flight read (0..1); pop = m_valid & m_ready;
  - rd_en = !empty & ((occ - pop) < 2);
  - the output buffer therefore never overflows.
- Latency: rd_en in cycle T -> rd_data sampled at end of T+1 -> m_valid high in T+2 when the buffer was empty. Sustained throughput is 1 word/cycle with m_ready held high.
- Output buffer:
  - FIFO-ordered, 2 entries; m_data and m_valid are driven from the head register;
  - m_data is stable while m_valid & !m_ready;
  - push and pop in the same cycle are both honoured.
- Boundaries:
  - empty: no rd_en is issued; m_valid falls after the last buffered word pops;
  - wptr_gray_sync advancing by several entries between cycles: reads continue until empty;
  - pointer wrap is seamless;
  - full is not computed here; it is the write side's job.

Decomposition:
- Package cdc_fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterized by width;
  - DATA_W and ADDR_W defaults shared with the write side.
- Sub-module fifo_out_skid: 2-entry valid/ready buffer with push, pop and occupancy count outputs. It is reusable on the write-side input.

Test Plan:
- Reset: assert rst mid-cycle -> immediately m_valid=0, rptr_gray=4'b0000, empty=1, level=0, rd_en=0.
- Single word:
  - stimulus: memory[0]=8'hA5, wptr_gray_sync 0000->0001 in cycle T, m_ready=1;
  - response: rd_en=1 and rd_addr=0 in T; rptr_gray=0001 after T; m_valid=1 with m_data=8'hA5 in T+2; empty=1 from T+1.
- Full burst:
  - stimulus: memory[i]=i for i=0..7, wptr_gray_sync=4'b1100 (8 entries), m_ready=1;
  - response: m_data 0..7 on 8 consecutive cycles; final rptr_gray=4'b1100; level=0.
- Backpressure:
  - stimulus: 8 entries available, m_ready=0;
  - response: exactly 2 rd_en pulses, then rd_en=0, m_data held at 8'h00 and level=6; on releasing m_ready, words 1..7 follow with no loss or duplication.
- Wrap-around:
  - stimulus: stream 20 words while the write model advances wptr in steps of 4;
  - response: data in order; after 20 reads rptr_gray=gray(4)=4'b0110; level never exceeds 8.
- Reset mid-burst:
  - stimulus: assert rst with 2 words buffered and 1 in flight, then release and restart with wptr_gray_sync=0001;
  - response: old words never appear; the first m_data comes from rd_addr=0.

Source files
------------

// File: rtl/cdc_fifo_pkg.sv
// Shared definitions for both halves of the dual-clock FIFO.
//   DATA_W_DEF / ADDR_W_DEF : default word width and address width
//   bin2gray / gray2bin     : pointer code conversion
package cdc_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  // Conversions work on a wide vector. Any narrower pointer can be used by
  // zero-extending it and size-casting the result back down. Zero upper bits
  // do not change the result, so one pair of functions serves every width.
  localparam int GRAY_MAX_W = 16;
  typedef logic [GRAY_MAX_W-1:0] gray_vec_t;

  function automatic gray_vec_t bin2gray(input gray_vec_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_vec_t gray2bin(input gray_vec_t g);
    gray_vec_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/cdc_fifo_rd_ctrl_if.sv
// Bundle of everything the read controller exchanges with the FIFO around it.
//   wptr_gray_sync / rptr_gray : pointer exchange with the write domain
//   rd_en / rd_addr / rd_data  : memory read port (registered read)
//   m_data / m_valid / m_ready : output stream
//   empty / level              : status
// The master modport is the controller; the slave modport is its surroundings.
interface cdc_fifo_rd_ctrl_if
  import cdc_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [ADDR_W:0]   wptr_gray_sync;
  logic [ADDR_W:0]   rptr_gray;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              empty;
  logic [ADDR_W:0]   level;

  modport master (
    input  wptr_gray_sync, rd_data, m_ready,
    output rptr_gray, rd_en, rd_addr, m_data, m_valid, empty, level
  );

  modport slave (
    output wptr_gray_sync, rd_data, m_ready,
    input  rptr_gray, rd_en, rd_addr, m_data, m_valid, empty, level
  );
endinterface

// File: rtl/fifo_out_skid.sv
// Two-entry FIFO-ordered valid/ready buffer.
//   clk, rst : clock, async active-high reset
//   push/din : write one word (ignored when full without a pop)
//   pop      : consume the head word (ignored when empty)
//   dout     : head word, held stable until popped
//   valid    : buffer non-empty
//   count    : occupancy 0..2
module fifo_out_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic [1:0]        count
);
  logic [DATA_W-1:0] head, tail;
  logic [1:0]        cnt;
  logic              pop_ok, push_ok;

  assign pop_ok  = pop & (cnt != 2'd0);
  assign push_ok = push & ((cnt != 2'd2) | pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) head <= din;
          else             tail <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // count unchanged; the incoming word lands behind whatever remains
          if (cnt == 2'd1) head <= din;
          else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = head;
  assign valid = (cnt != 2'd0);
  assign count = cnt;
endmodule

// File: rtl/cdc_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO, fully in the read clock domain.
//   clk, rst : read clock, async active-high reset
//   bus      : master side of cdc_fifo_rd_ctrl_if (pointer exchange, memory
//              read port, output stream, empty/level status)
// Reads are issued on credit: memory words already in flight or buffered never
// exceed the 2-entry output buffer, so the stream can be backpressured freely.
module cdc_fifo_rd_ctrl
  import cdc_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  cdc_fifo_rd_ctrl_if.master bus
);
  localparam int PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0]  rptr_bin, rptr_bin_next, rptr_gray_q, wptr_bin;
  logic              rd_en, empty, rd_inflight, pop;
  logic [1:0]        buf_cnt;
  logic [2:0]        occ_after_pop;
  logic [DATA_W-1:0] head_data;
  logic              head_vld;

  assign wptr_bin      = PTR_W'(gray2bin(GRAY_MAX_W'(bus.wptr_gray_sync)));
  assign rptr_bin_next = rptr_bin + PTR_W'(rd_en);

  // Reset forces the status view so nothing is read while the pointers clear,
  // even if the synchronized write pointer has not yet caught up.
  assign empty = rst | (rptr_gray_q == bus.wptr_gray_sync);

  assign pop           = head_vld & bus.m_ready;
  assign occ_after_pop = {1'b0, buf_cnt} + {2'b0, rd_inflight} - {2'b0, pop};
  assign rd_en         = ~empty & (occ_after_pop < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_bin    <= '0;
      rptr_gray_q <= '0;
      rd_inflight <= 1'b0;
    end else begin
      rptr_bin    <= rptr_bin_next;
      rptr_gray_q <= PTR_W'(bin2gray(GRAY_MAX_W'(rptr_bin_next)));
      rd_inflight <= rd_en;
    end
  end

  // rd_data is valid the cycle after the strobe, which is when rd_inflight is set
  fifo_out_skid #(.DATA_W(DATA_W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_inflight),
    .din   (bus.rd_data),
    .pop   (pop),
    .dout  (head_data),
    .valid (head_vld),
    .count (buf_cnt)
  );

  assign bus.rptr_gray = rptr_gray_q;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rptr_bin[ADDR_W-1:0];
  assign bus.m_data    = head_data;
  assign bus.m_valid   = head_vld;
  assign bus.empty     = empty;
  assign bus.level     = rst ? '0 : (wptr_bin - rptr_bin);
endmodule
